uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single `uart_tx` transmitter between up to four byte-stream requesters, e.g. the boot console, the debug monitor and the trap printer. It sits between the requesters and the `uart_tx` valid/ready port, replacing the direct `uart_reg_tx_ff`/`tx_valid_ff` drive in the UART top. It issues one-cycle valid pulses, waits for each byte to leave the line, and holds a grant for a whole message so that messages are never interleaved.

---
 rtl/uart_tx_arb.sv | 132 +++++++++++++
 tb/tb_uart_tx_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters,
// holding the grant for a whole message. Optional lock timeout: UART_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for tx_ready_i and a valid requester (owner only while locked)
// ISSUE     | tx_valid_o high for this single cycle
// WAIT_BUSY | waiting for uart_tx to drop ready (byte started)
// WAIT_IDLE | waiting for uart_tx to raise ready (byte finished)
module uart_tx_arb #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  input  logic                   err_clr_i,
  output logic                   timeout_err_o
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          lock;
  logic          accept;
  logic          timeout_hit;

  // Scan from the far end so the last hit is the first requester after rr_ptr.
  always_comb begin
    sel         = owner;
    cand        = '0;
    accept      = 1'b0;
    req_ready_o = '0;
    if (rst_n && state == IDLE && tx_ready_i) begin
      if (lock) begin
        accept = req_valid_i[owner];
      end else begin
        for (int k = NUM_REQ; k >= 1; k--) begin
          cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
          if (req_valid_i[cand]) begin
            sel    = cand;
            accept = 1'b1;
          end
        end
      end
    end
    if (accept) req_ready_o[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NUM_REQ - 1);
      owner      <= '0;
      lock       <= 1'b0;
      grant_o    <= '0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
    end else begin
      tx_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_data_o  <= req_data_i[{sel, 3'b000} +: 8];
            tx_valid_o <= 1'b1;
            grant_o    <= req_ready_o;
            owner      <= sel;
            lock       <= ~req_last_i[sel];
            if (req_last_i[sel]) rr_ptr <= sel;
            state      <= ISSUE;
          end else if (timeout_hit) begin
            lock    <= 1'b0;
            grant_o <= '0;
            rr_ptr  <= owner;
          end
        end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (!tx_ready_i) state <= WAIT_IDLE;
        WAIT_IDLE: begin
          if (tx_ready_i) begin
            state <= IDLE;
            if (!lock) grant_o <= '0;
          end
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE) || lock;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] lock_cnt;
  logic        idle_wait;

  // Only an owner that went quiet mid-message is timed; a stalled uart_tx is not.
  assign idle_wait   = (state == IDLE) && lock && !req_valid_i[owner];
  assign timeout_hit = idle_wait && (lock_cnt == 16'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt      <= 16'd0;
      timeout_err_o <= 1'b0;
    end else begin
      if (accept || timeout_hit) lock_cnt <= 16'd0;
      else if (idle_wait)        lock_cnt <= lock_cnt + 16'd1;
      if (timeout_hit)    timeout_err_o <= 1'b1;
      else if (err_clr_i) timeout_err_o <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  localparam int unused_lock_timeout = LOCK_TIMEOUT;

  assign unused_err_clr = err_clr_i;
  assign timeout_hit    = 1'b0;
  assign timeout_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester queues, a uart_tx ready model and a message-level
// round-robin reference. Exercises the timeout path when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;
  localparam int N  = 2;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [8*N-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic [7:0]     tx_data_o;
  logic           tx_valid_o;
  logic           tx_ready_i = 1'b1;
  logic           busy_o;
  logic           err_clr_i = 1'b0;
  logic           timeout_err_o;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .err_clr_i(err_clr_i), .timeout_err_o(timeout_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // requester queues: {last, byte}
  logic [8:0] rmem [N][64];
  int         rh [N];
  int         rt [N];

  // expected transmit order
  logic [7:0] exp_byte [512];
  int         exp_src  [512];
  int         n_exp, n_acc, n_sent;
  int         m_rr;

  // uart_tx model and sampled DUT state
  bit         tx_active, stall_en, prev_acc;
  int         tx_hold, tx_busy, busy_fix;
  logic       s_err, s_busy;
  logic [N-1:0] s_grant;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic last);
    rmem[r][rt[r]] = {last, b};
    rt[r]++;
  endtask

  task automatic expect_b(input int src, input logic [7:0] b, input logic last);
    exp_src[n_exp]  = src;
    exp_byte[n_exp] = b;
    n_exp++;
    if (last) m_rr = src;
  endtask

  // Whole messages are granted in round-robin order starting after the last finisher.
  task automatic model_rr();
    int  h [N];
    bit  found;
    logic [8:0] e;
    for (int r = 0; r < N; r++) h[r] = rh[r];
    do begin
      found = 1'b0;
      for (int k = 1; k <= N && !found; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (h[c] < rt[c]) begin
          found = 1'b1;
          do begin
            e = rmem[c][h[c]];
            h[c]++;
            expect_b(c, e[7:0], e[8]);
          end while (!e[8] && h[c] < rt[c]);
        end
      end
    end while (found);
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < N; r++) begin
      if (rh[r] < rt[r]) begin
        req_valid_i[r]        = 1'b1;
        req_data_i[8*r +: 8]  = rmem[r][rh[r]][7:0];
        req_last_i[r]         = rmem[r][rh[r]][8];
      end else begin
        req_valid_i[r]        = 1'b0;
        req_data_i[8*r +: 8]  = 8'h00;
        req_last_i[r]         = 1'b0;
      end
    end
  endtask

  task automatic step();
    int pop_r;
    pop_r = -1;
    @(negedge clk);
    check_val("valid_latency", tx_valid_o, prev_acc);
    prev_acc = (req_ready_o != '0);
    if (!tx_ready_i) check_val("no_accept_tx_busy", req_ready_o, 0);
    if (req_ready_o != '0) begin
      if (n_acc < n_exp) check_val("accept_src", req_ready_o, 32'(1) << exp_src[n_acc]);
      else               check_val("extra_accept", req_ready_o, 0);
      for (int r = 0; r < N; r++) if (req_ready_o[r]) pop_r = r;
      n_acc++;
    end
    if (tx_valid_o) begin
      check_val("single_pulse", tx_active, 0);
      if (n_sent < n_exp) begin
        check_val("tx_data", tx_data_o, exp_byte[n_sent]);
        check_val("grant", grant_o, 32'(1) << exp_src[n_sent]);
      end else begin
        check_val("extra_tx", tx_valid_o, 0);
      end
      n_sent++;
      tx_active = 1'b1;
      tx_hold   = $urandom_range(0, 3);
      tx_busy   = (busy_fix != 0) ? busy_fix : $urandom_range(1, 4);
    end
    s_err   = timeout_err_o;
    s_busy  = busy_o;
    s_grant = grant_o;
    @(posedge clk);
    #1;
    if (pop_r >= 0) rh[pop_r]++;
    if (tx_active) begin
      if (tx_hold > 0) begin
        tx_hold--;
        tx_ready_i = 1'b1;
      end else if (tx_busy > 0) begin
        tx_busy--;
        tx_ready_i = 1'b0;
      end else begin
        tx_active  = 1'b0;
        tx_ready_i = 1'b1;
      end
    end else begin
      tx_ready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    drive_reqs();
  endtask

  task automatic run_until_done(input int budget);
    int c;
    c = 0;
    while ((n_sent < n_exp || tx_active || s_busy) && c < budget) begin
      step();
      c++;
    end
    check_val("drain", {29'd0, n_sent < n_exp, tx_active, s_busy}, 0);
    check_val("idle_grant", s_grant, 0);
  endtask

  // Requesters keep data presented during reset; req_ready_o must stay low regardless.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) begin rh[r] = 0; rt[r] = 0; end
    tx_active = 1'b0; tx_ready_i = 1'b1; prev_acc = 1'b0;
    n_exp = 0; n_acc = 0; n_sent = 0; m_rr = N - 1;
    err_clr_i = 1'b0; stall_en = 1'b0; busy_fix = 0; s_busy = 1'b0; s_grant = '0;
    push(0, 8'h77, 1'b1);
    push(1, 8'h88, 1'b1);
    drive_reqs();
    #1;
    check_val("rst_ready", req_ready_o, 0);
    check_val("rst_grant", grant_o, 0);
    check_val("rst_tx_data", tx_data_o, 0);
    check_val("rst_tx_valid", tx_valid_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_err", timeout_err_o, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) begin rh[r] = 0; rt[r] = 0; end
    drive_reqs();
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    #2;
    do_reset();

    // single byte
    push(0, 8'h41, 1'b1);
    model_rr();
    drive_reqs();
    run_until_done(200);

    // message lock: req1 owns the line for A1..A3 while req0 waits with 55
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(0, 8'h55, 1'b1);
    model_rr();
    drive_reqs();
    run_until_done(400);

    // simultaneous single-byte pairs
    do_reset();
    push(0, 8'h30, 1'b1); push(0, 8'h32, 1'b1);
    push(1, 8'h31, 1'b1); push(1, 8'h33, 1'b1);
    model_rr();
    drive_reqs();
    run_until_done(400);

    // random messages with uart_tx stalls
    stall_en = 1'b1;
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < N; r++) begin
        rh[r] = 0; rt[r] = 0;
        for (int m = $urandom_range(0, 3); m > 0; m--) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 1; b <= len; b++) push(r, 8'($urandom), b == len);
        end
      end
      model_rr();
      drive_reqs();
      run_until_done(3000);
    end

    // owner goes quiet mid-message while req1 waits
    do_reset();
    push(0, 8'h5A, 1'b0);
    expect_b(0, 8'h5A, 1'b0);
    drive_reqs();
    c = 0;
    while (n_acc < 1 && c < 50) begin step(); c++; end
    push(1, 8'hC3, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    expect_b(1, 8'hC3, 1'b1);
`endif
    drive_reqs();
    c = 0;
    while ((n_sent < 1 || tx_active) && c < 100) begin step(); c++; end
    for (int k = 1; k <= 10; k++) begin
      step();
`ifdef UART_ARB_TIMEOUT_EN
      if (k == 9) begin
        check_val("to_err_early", s_err, 0);
        check_val("to_grant_held", s_grant, 1);
      end
      if (k == 10) begin
        check_val("to_err_set", s_err, 1);
        check_val("to_grant_clr", s_grant, 0);
      end
`else
      check_val("no_to_err", s_err, 0);
      check_val("lock_held", s_grant, 1);
`endif
    end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    step();
    check_val("err_after_clr", s_err, 0);
`ifndef UART_ARB_TIMEOUT_EN
    repeat (30) step();
    check_val("lock_still_held", s_grant, 1);
    push(0, 8'h5B, 1'b1);
    expect_b(0, 8'h5B, 1'b1);
    expect_b(1, 8'hC3, 1'b1);
    drive_reqs();
`endif
    run_until_done(400);

    // reset while a byte is on the line
    do_reset();
    busy_fix = 6;
    push(1, 8'h99, 1'b1);
    model_rr();
    drive_reqs();
    c = 0;
    while (!(n_sent == 1 && !tx_ready_i) && c < 100) begin step(); c++; end
    step();
    check_val("midframe_busy", s_busy, 1);
    check_val("midframe_grant", s_grant, 2);
    do_reset();
    push(1, 8'h88, 1'b1);
    push(0, 8'h77, 1'b1);
    model_rr();
    drive_reqs();
    run_until_done(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
